// File: rtl/cache_sram_pkg.sv
// cache_sram shared definitions.
// Init-FSM encoding and the per-lane merge used for collision forwarding.
package cache_sram_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int unsigned MAX_W = 256;

  // Lanes with mask[i]=1 take new_w, all other lanes keep old_w.
  // bw is the lane width in bits and must be non-zero.
  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_W-1:0] mask,
    input int unsigned      bw
  );
    logic [MAX_W-1:0] res;
    logic [7:0]       lane;
    res = old_w;
    for (int unsigned b = 0; b < MAX_W; b++) begin
      lane = 8'(b / bw);
      if (mask[lane]) begin
        res[b] = new_w[b];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_sram_sdp_ram_core.sv
// Plain simple-dual-port array: registered read-first output,
// per-lane write enables, no reset, shaped for block-RAM inference.
module sdp_ram_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BYTE_WIDTH = 8,
  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH,
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic [NB-1:0]         i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Lane-masked write and read-first registered read on one edge.
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
          i_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_sram.sv
// L1 cache tag/valid/data array: init sweep after reset,
// byte-lane writes, read/write collision forwarding, optional out reg.
module cache_sram
  import cache_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int unsigned OUT_REG = 0,
  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  input  logic [NB-1:0]         i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_init_busy
);

  state_t                r_state;
  state_t                w_state_nx;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_cnt_inc;

  logic [NB-1:0]         w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic                  w_ram_re;
  logic [DATA_WIDTH-1:0] w_core_rdata;

  logic                  w_coll;
  logic                  r_v1;
  logic [NB-1:0]         r_fwd_mask;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [MAX_W-1:0]      w_merge_full;
  logic [DATA_WIDTH-1:0] w_merged;

  // Init/run state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Sweep address counter; wraps to 0 as the sweep finishes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  // Next state and array port mux: sweep writes own the port in INIT.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_inc   = 1'b0;
    w_ram_we    = '0;
    w_ram_waddr = i_waddr;
    w_ram_wdata = i_wdata;
    w_ram_re    = 1'b0;
    unique case (r_state)
      S_INIT: begin
        if (!i_rst) begin
          w_ram_we    = '1;
          w_ram_waddr = r_cnt;
          w_ram_wdata = INIT_VALUE;
          w_cnt_inc   = 1'b1;
          if (&r_cnt) begin
            w_state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!i_rst) begin
          w_ram_we = i_we;
          w_ram_re = i_rd_en;
        end
      end
      default: begin
        w_state_nx = S_INIT;
      end
    endcase
  end

  assign o_init_busy = (r_state == S_INIT);

  sdp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_core (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (i_raddr),
    .o_rdata (w_core_rdata)
  );

  assign w_coll = w_ram_re && (|i_we) && (i_raddr == i_waddr);

  // Capture the forwarding lanes alongside each accepted read; they
  // only change with a new read so a held word stays intact.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1       <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else begin
      r_v1 <= w_ram_re;
      if (w_ram_re) begin
        r_fwd_mask <= w_coll ? i_we : '0;
        r_fwd_data <= i_wdata;
      end
    end
  end

  assign w_merge_full = lane_merge(
    MAX_W'(w_core_rdata),
    MAX_W'(r_fwd_data),
    MAX_W'(r_fwd_mask),
    BYTE_WIDTH
  );
  assign w_merged = w_merge_full[DATA_WIDTH-1:0];

  if (DATA_WIDTH < MAX_W) begin : g_pad
    logic w_unused;
    assign w_unused = ^w_merge_full[MAX_W-1:DATA_WIDTH];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_v;

    // Second stage: rvalid travels with the registered word.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_out_data <= '0;
        r_out_v    <= 1'b0;
      end else begin
        r_out_v <= r_v1;
        if (r_v1) begin
          r_out_data <= w_merged;
        end
      end
    end

    assign o_rdata  = r_out_data;
    assign o_rvalid = r_out_v;
  end else begin : g_noreg
    logic r_ok;

    // The array register has no reset; mask it until a read lands.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_ok <= 1'b0;
      end else if (w_ram_re) begin
        r_ok <= 1'b1;
      end
    end

    assign o_rdata  = r_ok ? w_merged : '0;
    assign o_rvalid = r_v1;
  end

endmodule

// File: tb/tb_cache_sram.sv
// Directed bench for cache_sram: OUT_REG=0 and OUT_REG=1 instances
// driven by identical stimulus, checked at latency 1 and 2.
module tb_cache_sram;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [3:0]  raddr;
  logic [3:0]  we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rd0, rd1;
  logic        rv0, rv1;
  logic        busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;

  cache_sram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .BYTE_WIDTH (8),
    .INIT_VALUE (32'hA5A5A5A5),
    .OUT_REG    (0)
  ) u_dut0 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_en     (rd_en),
    .i_raddr     (raddr),
    .o_rdata     (rd0),
    .o_rvalid    (rv0),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .o_init_busy (busy0)
  );

  cache_sram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .BYTE_WIDTH (8),
    .INIT_VALUE (32'hA5A5A5A5),
    .OUT_REG    (1)
  ) u_dut1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_en     (rd_en),
    .i_raddr     (raddr),
    .o_rdata     (rd1),
    .o_rvalid    (rv1),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .o_init_busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rd_en = 1'b0;
    raddr = '0;
    we    = '0;
    waddr = '0;
    wdata = '0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    n_cmp++;
    if ({busy0, rv0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL rst_d0: got busy=%b v=%b d=%h want 1 0 0",
               busy0, rv0, rd0);
    end
    n_cmp++;
    if ({busy1, rv1, rd1} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL rst_d1: got busy=%b v=%b d=%h want 1 0 0",
               busy1, rv1, rd1);
    end
    rst   = 1'b0;
    rd_en = 1'b1;
    raddr = 4'd0;
    we    = 4'hF;
    waddr = 4'd0;
    wdata = 32'hFFFFFFFF;
    n = 0;
    while (busy0 && n < 40) begin
      n_cmp++;
      if ({rv0, rv1} !== 2'b00) begin
        n_err++;
        $display("FAIL init_ignore: got rv0=%b rv1=%b want 0 0",
                 rv0, rv1);
      end
      cyc();
      n++;
    end
    idle();
    n_cmp++;
    if (n !== 16) begin
      n_err++;
      $display("FAIL init_len: got %0d busy cycles want 16", n);
    end
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL init_len_d1: got busy=%b want 0", busy1);
    end
    for (int a = 0; a < 18; a++) begin
      if (a < 16) begin
        rd_en = 1'b1;
        raddr = 4'(a);
      end else begin
        rd_en = 1'b0;
      end
      cyc();
      if (a < 16) begin
        n_cmp++;
        if ({rv0, rd0} !== {1'b1, 32'hA5A5A5A5}) begin
          n_err++;
          $display("FAIL init_rd_d0[%0d]: got v=%b d=%h want 1 a5a5a5a5",
                   a, rv0, rd0);
        end
      end
      if (a >= 1 && a <= 16) begin
        n_cmp++;
        if ({rv1, rd1} !== {1'b1, 32'hA5A5A5A5}) begin
          n_err++;
          $display("FAIL init_rd_d1[%0d]: got v=%b d=%h want 1 a5a5a5a5",
                   a - 1, rv1, rd1);
        end
      end
    end
    idle();
  endtask

  task automatic test_byte_we;
    we    = 4'hF;
    waddr = 4'd3;
    wdata = 32'h11223344;
    cyc();
    we    = 4'b0101;
    wdata = 32'hAABBCCDD;
    cyc();
    we    = 4'h0;
    rd_en = 1'b1;
    raddr = 4'd3;
    cyc();
    rd_en = 1'b0;
    n_cmp++;
    if ({rv0, rd0} !== {1'b1, 32'h11BB33DD}) begin
      n_err++;
      $display("FAIL byte_we_d0: got v=%b d=%h want 1 11bb33dd", rv0, rd0);
    end
    cyc();
    n_cmp++;
    if ({rv1, rd1} !== {1'b1, 32'h11BB33DD}) begin
      n_err++;
      $display("FAIL byte_we_d1: got v=%b d=%h want 1 11bb33dd", rv1, rd1);
    end
    n_cmp++;
    if ({rv0, rd0} !== {1'b0, 32'h11BB33DD}) begin
      n_err++;
      $display("FAIL byte_we_pulse_d0: got v=%b d=%h want 0 11bb33dd",
               rv0, rd0);
    end
    idle();
  endtask

  task automatic test_collision;
    we    = 4'hF;
    waddr = 4'd7;
    wdata = 32'h0;
    cyc();
    we    = 4'b1100;
    wdata = 32'hDEADBEEF;
    rd_en = 1'b1;
    raddr = 4'd7;
    cyc();
    n_cmp++;
    if ({rv0, rd0} !== {1'b1, 32'hDEAD0000}) begin
      n_err++;
      $display("FAIL coll_fwd_d0: got v=%b d=%h want 1 dead0000", rv0, rd0);
    end
    we = 4'h0;
    cyc();
    n_cmp++;
    if ({rv0, rd0} !== {1'b1, 32'hDEAD0000}) begin
      n_err++;
      $display("FAIL coll_after_d0: got v=%b d=%h want 1 dead0000", rv0, rd0);
    end
    n_cmp++;
    if ({rv1, rd1} !== {1'b1, 32'hDEAD0000}) begin
      n_err++;
      $display("FAIL coll_fwd_d1: got v=%b d=%h want 1 dead0000", rv1, rd1);
    end
    rd_en = 1'b0;
    cyc();
    n_cmp++;
    if ({rv1, rd1} !== {1'b1, 32'hDEAD0000}) begin
      n_err++;
      $display("FAIL coll_after_d1: got v=%b d=%h want 1 dead0000", rv1, rd1);
    end
    n_cmp++;
    if ({rv0, rd0} !== {1'b0, 32'hDEAD0000}) begin
      n_err++;
      $display("FAIL coll_hold_d0: got v=%b d=%h want 0 dead0000", rv0, rd0);
    end
    idle();
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [3];
    exp[0] = 32'h01010101;
    exp[1] = 32'h02020202;
    exp[2] = 32'h11BB33DD;
    we    = 4'hF;
    waddr = 4'd1;
    wdata = 32'h01010101;
    cyc();
    waddr = 4'd2;
    wdata = 32'h02020202;
    cyc();
    we = 4'h0;
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      raddr = 4'(k + 1);
      cyc();
      n_cmp++;
      if ({rv0, rd0} !== {1'b1, exp[k]}) begin
        n_err++;
        $display("FAIL b2b_d0[%0d]: got v=%b d=%h want 1 %h",
                 k, rv0, rd0, exp[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if ({rv1, rd1} !== {1'b1, exp[k-1]}) begin
          n_err++;
          $display("FAIL b2b_d1[%0d]: got v=%b d=%h want 1 %h",
                   k - 1, rv1, rd1, exp[k-1]);
        end
      end
    end
    rd_en = 1'b0;
    we    = 4'hF;
    waddr = 4'd3;
    wdata = 32'h33333333;
    cyc();
    n_cmp++;
    if ({rv0, rd0} !== {1'b0, 32'h11BB33DD}) begin
      n_err++;
      $display("FAIL hold_d0: got v=%b d=%h want 0 11bb33dd", rv0, rd0);
    end
    n_cmp++;
    if ({rv1, rd1} !== {1'b1, 32'h11BB33DD}) begin
      n_err++;
      $display("FAIL b2b_d1[2]: got v=%b d=%h want 1 11bb33dd", rv1, rd1);
    end
    we = 4'h0;
    cyc();
    n_cmp++;
    if ({rv0, rd0, rv1, rd1} !==
        {1'b0, 32'h11BB33DD, 1'b0, 32'h11BB33DD}) begin
      n_err++;
      $display("FAIL hold_both: got %b %h %b %h want 0 11bb33dd 0 11bb33dd",
               rv0, rd0, rv1, rd1);
    end
    rd_en = 1'b1;
    raddr = 4'd3;
    cyc();
    rd_en = 1'b0;
    n_cmp++;
    if ({rv0, rd0} !== {1'b1, 32'h33333333}) begin
      n_err++;
      $display("FAIL newdata_d0: got v=%b d=%h want 1 33333333", rv0, rd0);
    end
    cyc();
    n_cmp++;
    if ({rv1, rd1} !== {1'b1, 32'h33333333}) begin
      n_err++;
      $display("FAIL newdata_d1: got v=%b d=%h want 1 33333333", rv1, rd1);
    end
    idle();
  endtask

  task automatic test_mid_reset;
    int n;
    rd_en = 1'b1;
    raddr = 4'd1;
    cyc();
    n_cmp++;
    if ({rv0, rd0} !== {1'b1, 32'h01010101}) begin
      n_err++;
      $display("FAIL pre_rst_d0: got v=%b d=%h want 1 01010101", rv0, rd0);
    end
    rst = 1'b1;
    idle();
    cyc();
    n_cmp++;
    if ({busy0, rv0, rd0, busy1, rv1, rd1} !==
        {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL rd_rst: got %b %b %h %b %b %h want 1 0 0 1 0 0",
               busy0, rv0, rd0, busy1, rv1, rd1);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({busy0, busy1, rv1} !== 3'b110) begin
        n_err++;
        $display("FAIL sweep_busy[%0d]: got %b%b rv1=%b want 11 0",
                 i, busy0, busy1, rv1);
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    n_cmp++;
    if ({busy0, rv0, rd0, busy1, rv1, rd1} !==
        {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL mid_rst: got %b %b %h %b %b %h want 1 0 0 1 0 0",
               busy0, rv0, rd0, busy1, rv1, rd1);
    end
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (n !== 16 || busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL re_sweep_len: got %0d cycles busy1=%b want 16 0",
               n, busy1);
    end
    rd_en = 1'b1;
    raddr = 4'd3;
    cyc();
    raddr = 4'd7;
    n_cmp++;
    if ({rv0, rd0} !== {1'b1, 32'hA5A5A5A5}) begin
      n_err++;
      $display("FAIL re_init3_d0: got v=%b d=%h want 1 a5a5a5a5", rv0, rd0);
    end
    cyc();
    rd_en = 1'b0;
    n_cmp++;
    if ({rv0, rd0, rv1, rd1} !==
        {1'b1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5}) begin
      n_err++;
      $display("FAIL re_init7: got %b %h %b %h want 1 a5a5a5a5 1 a5a5a5a5",
               rv0, rd0, rv1, rd1);
    end
    cyc();
    n_cmp++;
    if ({rv1, rd1} !== {1'b1, 32'hA5A5A5A5}) begin
      n_err++;
      $display("FAIL re_init7_d1: got v=%b d=%h want 1 a5a5a5a5", rv1, rd1);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_byte_we();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
